regfile_scoreboard: RTL and testbench



---
 rtl/regfile_pkg.sv | 11 +
 rtl/wb_extend.sv | 27 ++
 rtl/regfile_scoreboard.sv | 74 +++++++
 tb/tb_regfile_scoreboard.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - write-back extension mode encodings for the register file
package regfile_pkg;

    typedef logic [1:0] wb_mode_t;

    localparam wb_mode_t WB_FULL = 2'd0;
    localparam wb_mode_t WB_ZB   = 2'd1;
    localparam wb_mode_t WB_ZH   = 2'd2;
    localparam wb_mode_t WB_SW   = 2'd3;

endpackage

// File: rtl/wb_extend.sv
// rtl/wb_extend.sv - load-width zero/sign extension of the write-back value
module wb_extend
    import regfile_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  wb_mode_t          mode,
    input  logic [XLEN-1:0]   data,
    output logic [XLEN-1:0]   ext
);

    logic signed [31:0] word;

    assign word = data[31:0];

    // Signed size cast replicates bit 31; at XLEN=32 it degenerates to FULL.
    always_comb begin
        ext = data;
        case (mode)
            WB_ZB:   ext = XLEN'(data[7:0]);
            WB_ZH:   ext = XLEN'(data[15:0]);
            WB_SW:   ext = XLEN'(word);
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - dual-read register file with write bypass and busy scoreboard
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int XLEN = 64,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_en,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    output logic            rsv_conflict,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  wb_mode_t        wb_mode,
    input  logic [XLEN-1:0] wb_data
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [XLEN-1:0] wb_val;
    logic            byp1;
    logic            byp2;
    logic            wb_retires_rsv;

    wb_extend #(.XLEN(XLEN)) u_wb_extend (
        .mode (wb_mode),
        .data (wb_data),
        .ext  (wb_val)
    );

    assign byp1           = wb_en && (wb_addr == rs1_addr);
    assign byp2           = wb_en && (wb_addr == rs2_addr);
    assign wb_retires_rsv = wb_en && (wb_addr == rsv_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy         <= '0;
            rs1_data     <= '0;
            rs2_data     <= '0;
            rs1_busy     <= 1'b0;
            rs2_busy     <= 1'b0;
            rsv_conflict <= 1'b0;
        end else begin
            if (wb_en) begin
                regs[wb_addr] <= wb_val;
                busy[wb_addr] <= 1'b0;
            end
            // The reserve update follows the write-back so a same-address reserve wins.
            rsv_conflict <= rsv_en && busy[rsv_addr] && !wb_retires_rsv;
            if (rsv_en) begin
                busy[rsv_addr] <= 1'b1;
            end
            if (rd_en) begin
                rs1_data <= byp1 ? wb_val : regs[rs1_addr];
                rs2_data <= byp2 ? wb_val : regs[rs2_addr];
                rs1_busy <= byp1 ? 1'b0 : busy[rs1_addr];
                rs2_busy <= byp2 ? 1'b0 : busy[rs2_addr];
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed vector bench for regfile_scoreboard
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            rd_en;
    logic [AW-1:0]   rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            rs1_busy, rs2_busy;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            rsv_conflict;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    wb_mode_t        wb_mode;
    logic [XLEN-1:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rsv_en       (rsv_en),
        .rsv_addr     (rsv_addr),
        .rsv_conflict (rsv_conflict),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_mode      (wb_mode),
        .wb_data      (wb_data)
    );

    typedef struct {
        logic            rd;
        logic [AW-1:0]   a1;
        logic [AW-1:0]   a2;
        logic            rsv;
        logic [AW-1:0]   ra;
        logic            wb;
        logic [AW-1:0]   wa;
        wb_mode_t        wm;
        logic [XLEN-1:0] wd;
        logic [XLEN-1:0] e_d1;
        logic [XLEN-1:0] e_d2;
        logic            e_b1;
        logic            e_b2;
        logic            e_c;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input int idx, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rd_en = 0; rs1_addr = 0; rs2_addr = 0;
        rsv_en = 0; rsv_addr = 0;
        wb_en = 0; wb_addr = 0; wb_mode = WB_FULL; wb_data = '0;
    endtask

    task automatic check_outputs(input int idx, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                                 input logic b1, input logic b2, input logic c);
        check("rs1_data", idx, rs1_data, d1);
        check("rs2_data", idx, rs2_data, d2);
        check("rs1_busy", idx, XLEN'(rs1_busy), XLEN'(b1));
        check("rs2_busy", idx, XLEN'(rs2_busy), XLEN'(b2));
        check("rsv_conflict", idx, XLEN'(rsv_conflict), XLEN'(c));
    endtask

    task automatic set_vec(input int i, input logic rd, input int a1, input int a2,
                           input logic rsv, input int ra, input logic wb, input int wa,
                           input wb_mode_t wm, input logic [XLEN-1:0] wd,
                           input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                           input logic b1, input logic b2, input logic c);
        vecs[i] = '{rd, AW'(a1), AW'(a2), rsv, AW'(ra), wb, AW'(wa), wm, wd, d1, d2, b1, b2, c};
    endtask

    initial begin
        //        rd  a1 a2 rsv ra  wb wa  mode     wd                      e_d1                    e_d2                    b1 b2 c
        set_vec( 0, 1,  0,31, 0, 0, 0, 0, WB_FULL, 64'h0,                  64'h0,                  64'h0,                  0, 0, 0);
        set_vec( 1, 0,  0, 0, 0, 0, 1, 5, WB_SW,   64'h0000_0000_8000_0001, 64'h0,                 64'h0,                  0, 0, 0);
        set_vec( 2, 1,  5, 5, 0, 0, 0, 0, WB_FULL, 64'h0,                  64'hFFFF_FFFF_8000_0001, 64'hFFFF_FFFF_8000_0001, 0, 0, 0);
        set_vec( 3, 1,  5, 0, 0, 0, 1, 5, WB_ZB,   64'hFFFF_FFFF_FFFF_FF80, 64'h80,                64'h0,                  0, 0, 0);
        set_vec( 4, 1,  7, 5, 0, 0, 1, 7, WB_FULL, 64'h1234,               64'h1234,               64'h80,                 0, 0, 0);
        set_vec( 5, 0,  0, 0, 1, 9, 0, 0, WB_FULL, 64'h0,                  64'h1234,               64'h80,                 0, 0, 0);
        set_vec( 6, 1,  9, 7, 0, 0, 0, 0, WB_FULL, 64'h0,                  64'h0,                  64'h1234,               1, 0, 0);
        set_vec( 7, 0,  0, 0, 0, 0, 1, 9, WB_FULL, 64'hDEAD,               64'h0,                  64'h1234,               1, 0, 0);
        set_vec( 8, 1,  9, 9, 0, 0, 0, 0, WB_FULL, 64'h0,                  64'hDEAD,               64'hDEAD,               0, 0, 0);
        set_vec( 9, 0,  0, 0, 1, 9, 0, 0, WB_FULL, 64'h0,                  64'hDEAD,               64'hDEAD,               0, 0, 0);
        set_vec(10, 0,  0, 0, 1, 9, 0, 0, WB_FULL, 64'h0,                  64'hDEAD,               64'hDEAD,               0, 0, 1);
        set_vec(11, 0,  0, 0, 0, 0, 0, 0, WB_FULL, 64'h0,                  64'hDEAD,               64'hDEAD,               0, 0, 0);
        set_vec(12, 1,  9, 3, 0, 0, 0, 0, WB_FULL, 64'h0,                  64'hDEAD,               64'h0,                  1, 0, 0);
        set_vec(13, 1,  3, 3, 1, 3, 1, 3, WB_FULL, 64'hAA,                 64'hAA,                 64'hAA,                 0, 0, 0);
        set_vec(14, 1,  3, 3, 0, 0, 0, 0, WB_FULL, 64'h0,                  64'hAA,                 64'hAA,                 1, 1, 0);
        set_vec(15, 1,  9, 3, 1, 3, 1, 3, WB_FULL, 64'hBB,                 64'hDEAD,               64'hBB,                 1, 0, 0);
        set_vec(16, 1,  3, 9, 0, 0, 1, 9, WB_ZH,   64'h1_2345_6789,        64'hBB,                 64'h6789,               1, 0, 0);
        set_vec(17, 1,  9,31, 0, 0, 1,31, WB_SW,   64'hFFFF_FFFF_7FFF_FFFF, 64'h6789,              64'h7FFF_FFFF,          0, 0, 0);
        set_vec(18, 1, 31, 0, 0, 0, 0, 0, WB_FULL, 64'h0,                  64'h7FFF_FFFF,          64'h0,                  0, 0, 0);

        // Reset with every strobe active: the writes and reserves must be ignored.
        idle_inputs();
        rst = 1;
        rd_en = 1; rs1_addr = 1; rs2_addr = 2;
        wb_en = 1; wb_addr = 1; wb_data = '1;
        rsv_en = 1; rsv_addr = 2;
        repeat (2) @(posedge clk);
        #1;
        check_outputs(100, '0, '0, 0, 0, 0);
        @(negedge clk);
        rst = 0;
        idle_inputs();
        rd_en = 1; rs1_addr = 1; rs2_addr = 2;
        @(posedge clk); #1;
        check_outputs(101, '0, '0, 0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            rd_en = vecs[i].rd; rs1_addr = vecs[i].a1; rs2_addr = vecs[i].a2;
            rsv_en = vecs[i].rsv; rsv_addr = vecs[i].ra;
            wb_en = vecs[i].wb; wb_addr = vecs[i].wa; wb_mode = vecs[i].wm; wb_data = vecs[i].wd;
            @(posedge clk); #1;
            check_outputs(i, vecs[i].e_d1, vecs[i].e_d2, vecs[i].e_b1, vecs[i].e_b2, vecs[i].e_c);
        end

        // Mid-stream reset drops a pending reservation and a written value.
        @(negedge clk);
        idle_inputs();
        rsv_en = 1; rsv_addr = 4;
        @(negedge clk);
        idle_inputs();
        wb_en = 1; wb_addr = 6; wb_data = 64'h55;
        @(negedge clk);
        idle_inputs();
        rd_en = 1; rs1_addr = 4; rs2_addr = 6;
        @(posedge clk); #1;
        check_outputs(200, 64'h0, 64'h55, 1, 0, 0);
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        check_outputs(201, '0, '0, 0, 0, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        check_outputs(202, '0, '0, 0, 0, 0);
        // A fresh reserve after reset must not see a stale busy bit.
        @(negedge clk);
        idle_inputs();
        rsv_en = 1; rsv_addr = 4;
        @(posedge clk); #1;
        check("rsv_conflict", 203, XLEN'(rsv_conflict), XLEN'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
